// File: rtl/rotate16_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit right rotator.
// Define ROTARB_STATS_EN to build the per-requester grant counters.
module rotate16_arbiter #(
    parameter int RESET_PRIO = 0,
    parameter int STAT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [15:0]       req0_data,
    input  logic [3:0]        req0_amt,
    input  logic              req0_left,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [15:0]       req1_data,
    input  logic [3:0]        req1_amt,
    input  logic              req1_left,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_id,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        prio_q;
    logic        id_q;
    logic [15:0] op_q;
    logic [3:0]  amt_q;
    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic        out_id_q;

    logic        gnt_any;
    logic        gnt_id;
    logic [15:0] sel_data;
    logic [3:0]  sel_amt;
    logic        sel_left;
    logic [3:0]  amt_d;
    logic [15:0] rot_res;

    // Priority only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt_any  = (state_q == IDLE) && (req0_valid || req1_valid);
        gnt_id   = (req0_valid && req1_valid) ? prio_q : req1_valid;
        sel_data = gnt_id ? req1_data : req0_data;
        sel_amt  = gnt_id ? req1_amt  : req0_amt;
        sel_left = gnt_id ? req1_left : req0_left;
        amt_d    = sel_left ? (4'd0 - sel_amt) : sel_amt;
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any &&  gnt_id;

    // Right rotate: result bit i takes operand bit (i + amt) mod 16.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rot
            logic [3:0] src_idx;
            assign src_idx     = 4'(gi) + amt_q;
            assign rot_res[gi] = op_q[src_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'(RESET_PRIO);
            id_q        <= 1'b0;
            op_q        <= 16'h0000;
            amt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q    <= sel_data;
                        amt_q   <= amt_d;
                        id_q    <= gnt_id;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    out_data_q  <= rot_res;
                    out_id_q    <= id_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        prio_q      <= ~id_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef ROTARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q;
    logic [STAT_W-1:0] cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_valid && req0_ready) cnt0_q <= cnt0_q + 1'b1;
            if (req1_valid && req1_ready) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule
